// File: rtl/fetch_lockstep_cmp.sv
// Lockstep checker for the dual-core Z80 harness: captures each core's M1 fetch
// addresses into per-channel FIFOs and compares the two streams in order.
module fetch_lockstep_cmp #(
  parameter int AW      = 16,
  parameter int DEPTH_L = 3,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             A_M1,
  input  logic [AW-1:0]    A_ADDR,
  input  logic             B_M1_N,
  input  logic             B_MREQ_N,
  input  logic [AW-1:0]    B_ADDR,
  input  logic             CHECK_EN,
  input  logic             BLOCK,
  input  logic             CLEAR,
  output logic             RUNNING,
  output logic             HALTED,
  output logic             MISMATCH,
  output logic             OVERFLOW,
  output logic             START_P,
  output logic [AW-1:0]    ERR_A,
  output logic [AW-1:0]    ERR_B,
  output logic [CNT_W-1:0] MATCH_CNT
);

  localparam int DEPTH = 1 << DEPTH_L;
  localparam logic [DEPTH_L:0] FULL_CNT = (DEPTH_L+1)'(DEPTH);
  localparam logic [DEPTH_L:0] ZERO_CNT = {(DEPTH_L+1){1'b0}};

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic                 fa_q_r, fb_q_r;
  logic [AW-1:0]        mem_a_r [DEPTH];
  logic [AW-1:0]        mem_b_r [DEPTH];
  logic [DEPTH_L-1:0]   wp_a_r, rp_a_r, wp_b_r, rp_b_r;
  logic [DEPTH_L:0]     cnt_a_r, cnt_b_r;
  logic                 running_r, halted_r, mismatch_r, overflow_r, start_p_r;
  logic [AW-1:0]        err_a_r, err_b_r;
  logic [CNT_W-1:0]     match_cnt_r;

  logic                 fa_s, fb_s, push_a_s, push_b_s, full_a_s, full_b_s;
  logic                 write_a_s, write_b_s, ovf_s, both_s, eq_s;
  logic [AW-1:0]        head_a_s, head_b_s;
  logic                 pop_a_s, pop_b_s, inc_s, start_s, err_s, flush_s;

  assign fa_s      = A_M1;
  assign fb_s      = ~B_M1_N & ~B_MREQ_N;
  assign push_a_s  = fa_s & ~fa_q_r;
  assign push_b_s  = fb_s & ~fb_q_r;
  // Fullness is judged on the pre-pop count, so a simultaneous pop never rescues a push.
  assign full_a_s  = (cnt_a_r == FULL_CNT);
  assign full_b_s  = (cnt_b_r == FULL_CNT);
  assign ovf_s     = (push_a_s & full_a_s) | (push_b_s & full_b_s);
  assign head_a_s  = mem_a_r[rp_a_r];
  assign head_b_s  = mem_b_r[rp_b_r];
  assign both_s    = (cnt_a_r != ZERO_CNT) & (cnt_b_r != ZERO_CNT);
  assign eq_s      = (head_a_s == head_b_s);
  assign write_a_s = push_a_s & ~full_a_s & ~flush_s;
  assign write_b_s = push_b_s & ~full_b_s & ~flush_s;

  // Compare decision and next state; overflow overrides every pop and transition.
  always_comb begin
    pop_a_s     = 1'b0;
    pop_b_s     = 1'b0;
    inc_s       = 1'b0;
    start_s     = 1'b0;
    err_s       = 1'b0;
    flush_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_SYNC: begin
        if (both_s && eq_s) begin
          pop_a_s     = 1'b1;
          pop_b_s     = 1'b1;
          start_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (both_s) begin
          pop_a_s = 1'b1;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_RUN: begin
        if (both_s && eq_s) begin
          pop_a_s = 1'b1;
          pop_b_s = 1'b1;
          inc_s   = 1'b1;
        end else if (both_s && (BLOCK || !CHECK_EN)) begin
          pop_a_s = 1'b1;
          pop_b_s = 1'b1;
        end else if (both_s) begin
          err_s       = 1'b1;
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (CLEAR) begin
          flush_s     = 1'b1;
          state_nxt_s = ST_SYNC;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: state_nxt_s = ST_SYNC;
    endcase
    if (ovf_s) begin
      pop_a_s     = 1'b0;
      pop_b_s     = 1'b0;
      inc_s       = 1'b0;
      start_s     = 1'b0;
      flush_s     = 1'b0;
      state_nxt_s = ST_HALT;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked by the counts.
  always_ff @(posedge CLK) begin
    if (write_a_s) mem_a_r[wp_a_r] <= A_ADDR;
    if (write_b_s) mem_b_r[wp_b_r] <= B_ADDR;
  end

  // Control state, FIFO pointers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_SYNC;
      fa_q_r      <= 1'b0;
      fb_q_r      <= 1'b0;
      wp_a_r      <= '0;
      rp_a_r      <= '0;
      wp_b_r      <= '0;
      rp_b_r      <= '0;
      cnt_a_r     <= ZERO_CNT;
      cnt_b_r     <= ZERO_CNT;
      running_r   <= 1'b0;
      halted_r    <= 1'b0;
      mismatch_r  <= 1'b0;
      overflow_r  <= 1'b0;
      start_p_r   <= 1'b0;
      err_a_r     <= '0;
      err_b_r     <= '0;
      match_cnt_r <= '0;
    end else begin
      fa_q_r    <= fa_s;
      fb_q_r    <= fb_s;
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      halted_r  <= (state_nxt_s == ST_HALT);
      start_p_r <= start_s;
      if (flush_s) begin
        wp_a_r  <= '0;
        rp_a_r  <= '0;
        wp_b_r  <= '0;
        rp_b_r  <= '0;
        cnt_a_r <= ZERO_CNT;
        cnt_b_r <= ZERO_CNT;
      end else begin
        wp_a_r  <= wp_a_r + DEPTH_L'(write_a_s);
        rp_a_r  <= rp_a_r + DEPTH_L'(pop_a_s);
        wp_b_r  <= wp_b_r + DEPTH_L'(write_b_s);
        rp_b_r  <= rp_b_r + DEPTH_L'(pop_b_s);
        cnt_a_r <= cnt_a_r + (DEPTH_L+1)'(write_a_s) - (DEPTH_L+1)'(pop_a_s);
        cnt_b_r <= cnt_b_r + (DEPTH_L+1)'(write_b_s) - (DEPTH_L+1)'(pop_b_s);
      end
      if (ovf_s) overflow_r <= 1'b1;
      if (err_s) begin
        mismatch_r <= 1'b1;
        err_a_r    <= head_a_s;
        err_b_r    <= head_b_s;
      end
      if (inc_s) match_cnt_r <= match_cnt_r + CNT_W'(1'b1);
    end
  end

  assign RUNNING   = running_r;
  assign HALTED    = halted_r;
  assign MISMATCH  = mismatch_r;
  assign OVERFLOW  = overflow_r;
  assign START_P   = start_p_r;
  assign ERR_A     = err_a_r;
  assign ERR_B     = err_b_r;
  assign MATCH_CNT = match_cnt_r;

endmodule
